seg7_scan_pwm: RTL and testbench
================================

Name: seg7_scan_pwm

Overview:
Parametrised multiplexed 7-segment display driver. It scans DIGITS hex digits and adds the following over the earlier fixed 8-digit scanner:
- per-digit enable and decimal point
- 4-bit PWM brightness with a built-in inter-digit blanking gap
- optional leading-zero suppression
- frame-coherent data snapshot, so the display never tears
- chip-select and segment outputs aligned on the same clock edge

It sits between status/debug registers and the board's seven-segment pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16); IW = max(1, clog2(DIGITS)).
SCAN_BITS, 17, one digit slot lasts 2^SCAN_BITS clk cycles (must be >= 4).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
num_data  in  4*DIGITS  hex nibbles; digit 0 = num_data[4*DIGITS-1 -: 4] (leftmost).
dp_in  in  DIGITS  decimal point request; bit DIGITS-1-i belongs to digit i.
digit_en  in  DIGITS  digit enable; bit DIGITS-1-i belongs to digit i; 0 = digit kept dark.
brightness  in  4  PWM duty in sixteenths (0 = dark, 15 = 15/16).
lzs_en  in  1  leading-zero suppression enable.
num_csn  out  DIGITS  active-low digit select; digit i drives bit DIGITS-1-i.
num_a_g  out  7  active-low segments, [6]=a ... [0]=g.
num_dp  out  1  active-low decimal point.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Every register updates only on the posedge of clk.
- Reset values: num_csn = all 1s, num_a_g = 7'h7F, num_dp = 1. Divider, digit index and snapshot all clear to 0. Reset mid-frame blanks the outputs on the next edge; the scan restarts at digit 0, slot start.
- Divider: SCAN_BITS-bit counter, increments every cycle and wraps to 0.
- Digit index: advances on divider wrap. From DIGITS-1 it wraps to 0; non-power-of-2 DIGITS never visit unused indices.
- Subphase: sub = divider[SCAN_BITS-1 -: 4].
- Snapshot: when divider==0 and index==0, num_data, dp_in, digit_en, brightness and lzs_en are copied into shadow registers. All decode uses the shadow copies, so input changes become visible only at the next frame start.
- Lit condition for digit i: shadow digit_en bit set AND sub < shadow brightness AND not suppressed.
  - Brightness 15 leaves sub 15 dark in every slot; this is the anti-ghosting gap.
  - Brightness 0 keeps the display fully dark.
- Leading-zero suppression (shadow lzs_en=1): digit i is suppressed if nibbles 0..i are all zero and i != DIGITS-1. The last digit is never suppressed, so value 0 shows a single "0".
- Pipeline:
  - Stage A registers index, lit and nibble from the current divider/index.
  - Stage B registers num_csn, num_a_g and num_dp together.
  - Outputs therefore reflect the divider state of 2 cycles earlier. num_csn and num_a_g never change on different edges.
- Lit digit outputs:
  - num_csn has only the digit's bit at 0.
  - num_a_g is decoded from the nibble.
  - num_dp = ~(shadow dp bit).
- Unlit digit outputs: num_csn = all 1s, num_a_g = 7'h7F, num_dp = 1.
- Decode table (a..g, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- At most one num_csn bit is low in any cycle.

Test Plan:
All scenarios use DIGITS=4 and SCAN_BITS=4 (16 cycles per slot, sub = divider).
1. Reset: hold rst 3 cycles with arbitrary inputs -> num_csn=4'hF, num_a_g=7'h7F, num_dp=1 during reset and for 2 cycles after release.
2. Basic scan: num_data=16'h12AF, digit_en=4'hF, brightness=15, lzs_en=0 ->
   - slot 0: num_csn=4'b0111 with 1001111 for 15 cycles, then 1 cycle blank.
   - slot 1: 4'b1011 with 0010010.
   - slot 2: 4'b1101 with 0001000.
   - slot 3: 4'b1110 with 0111000.
   - then repeats from slot 0.
3. PWM: brightness=4 -> each slot lit exactly 4 consecutive cycles, then 12 blank. brightness=0 -> num_csn stays 4'hF for a full frame.
4. LZS: lzs_en=1, num_data=16'h0005 -> slots 0-2 dark, slot 3 shows 0100100. num_data=16'h0000 -> only slot 3 lit, showing 0000001. num_data=16'h0105 -> slot 0 dark, slots 1-3 shown.
5. Snapshot/DP/enable: change num_data from 16'h1111 to 16'h2222 mid slot 1 -> slots 1-3 still show "1"; "2" appears from the next frame's slot 0. With digit_en=4'b1010 and dp_in=4'b1000 -> only slots 0 and 2 lit, num_dp=0 only in slot 0.
6. Reset mid-frame: assert rst during slot 2 -> outputs blank on the next edge; after release, scanning restarts at slot 0, 2 cycles later.

Source files
------------

// File: rtl/seg7_scan_pwm.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_pwm
// Purpose  : Multiplexed 7-segment scanner with per-digit enable/DP,
//            4-bit PWM brightness with a blanking gap, leading-zero
//            suppression, and a frame-coherent input snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_pwm #(
    parameter int DIGITS    = 8,
    parameter int SCAN_BITS = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   num_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [3:0]            brightness,
    input  logic                  lzs_en,
    output logic [DIGITS-1:0]     num_csn,
    output logic [6:0]            num_a_g,
    output logic                  num_dp
);

    localparam int                  IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]       C_LAST_IDX = IW'(DIGITS - 1);
    localparam logic [IW-1:0]       C_IDX_ONE  = IW'(1);
    localparam logic [SCAN_BITS-1:0] C_DIV_ONE = SCAN_BITS'(1);

    // Scan counters
    logic [SCAN_BITS-1:0] div_q, div_d;
    logic [IW-1:0]        idx_q, idx_d;

    // Frame snapshot of the inputs
    logic [4*DIGITS-1:0]  sh_data_q, sh_data_d;
    logic [DIGITS-1:0]    sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]    sh_en_q, sh_en_d;
    logic [3:0]           sh_br_q, sh_br_d;
    logic                 sh_lzs_q, sh_lzs_d;

    // Stage A
    logic [IW-1:0]        a_idx_q, a_idx_d;
    logic                 a_lit_q, a_lit_d;
    logic [3:0]           a_nib_q, a_nib_d;
    logic                 a_dp_q, a_dp_d;

    // Stage B (pin drivers)
    logic [DIGITS-1:0]    csn_q, csn_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    // Effective (snapshot-coherent) view of the inputs for the current cycle
    logic                 w_frame_start;
    logic [4*DIGITS-1:0]  w_data;
    logic [DIGITS-1:0]    w_dp;
    logic [DIGITS-1:0]    w_en;
    logic [3:0]           w_br;
    logic                 w_lzs;
    logic [3:0]           w_sub;
    logic                 w_zero_run;
    logic                 w_supp;
    logic                 w_en_bit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'b0000001;
            4'h1:    seg_decode = 7'b1001111;
            4'h2:    seg_decode = 7'b0010010;
            4'h3:    seg_decode = 7'b0000110;
            4'h4:    seg_decode = 7'b1001100;
            4'h5:    seg_decode = 7'b0100100;
            4'h6:    seg_decode = 7'b0100000;
            4'h7:    seg_decode = 7'b0001111;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0000100;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b1100000;
            4'hC:    seg_decode = 7'b0110001;
            4'hD:    seg_decode = 7'b1000010;
            4'hE:    seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    // Divider/index stepping and snapshot capture at frame start
    always_comb begin
        w_frame_start = (div_q == '0) && (idx_q == '0);
        div_d = div_q + C_DIV_ONE;
        idx_d = idx_q;
        if (div_q == '1) begin
            idx_d = (idx_q == C_LAST_IDX) ? '0 : idx_q + C_IDX_ONE;
        end
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        sh_br_d   = sh_br_q;
        sh_lzs_d  = sh_lzs_q;
        if (w_frame_start) begin
            sh_data_d = num_data;
            sh_dp_d   = dp_in;
            sh_en_d   = digit_en;
            sh_br_d   = brightness;
            sh_lzs_d  = lzs_en;
        end
        // The first cycle of a frame uses the values being captured, so the
        // whole frame (including its very first subphase) is coherent.
        w_data = w_frame_start ? num_data   : sh_data_q;
        w_dp   = w_frame_start ? dp_in      : sh_dp_q;
        w_en   = w_frame_start ? digit_en   : sh_en_q;
        w_br   = w_frame_start ? brightness : sh_br_q;
        w_lzs  = w_frame_start ? lzs_en     : sh_lzs_q;
    end

    // Stage A: select the current digit and decide whether it is lit
    always_comb begin
        w_sub      = div_q[SCAN_BITS-1 -: 4];
        w_zero_run = 1'b1;
        w_supp     = 1'b0;
        w_en_bit   = 1'b0;
        a_nib_d    = 4'h0;
        a_dp_d     = 1'b0;
        a_idx_d    = idx_q;
        for (int j = 0; j < DIGITS; j++) begin
            // Running "all nibbles up to here are zero" from the left
            w_zero_run = w_zero_run & (w_data[4*(DIGITS-1-j) +: 4] == 4'h0);
            if (idx_q == IW'(j)) begin
                a_nib_d  = w_data[4*(DIGITS-1-j) +: 4];
                a_dp_d   = w_dp[DIGITS-1-j];
                w_en_bit = w_en[DIGITS-1-j];
                w_supp   = w_lzs && w_zero_run && (j != DIGITS - 1);
            end
        end
        a_lit_d = w_en_bit && (w_sub < w_br) && !w_supp;
    end

    // Stage B: build chip-select, segments and DP together
    always_comb begin
        csn_d = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (a_lit_q) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (a_idx_q == IW'(j)) begin
                    csn_d[DIGITS-1-j] = 1'b0;
                end
            end
            seg_d = seg_decode(a_nib_q);
            dp_d  = ~a_dp_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            sh_br_q   <= '0;
            sh_lzs_q  <= 1'b0;
            a_idx_q   <= '0;
            a_lit_q   <= 1'b0;
            a_nib_q   <= 4'h0;
            a_dp_q    <= 1'b0;
            csn_q     <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            sh_en_q   <= sh_en_d;
            sh_br_q   <= sh_br_d;
            sh_lzs_q  <= sh_lzs_d;
            a_idx_q   <= a_idx_d;
            a_lit_q   <= a_lit_d;
            a_nib_q   <= a_nib_d;
            a_dp_q    <= a_dp_d;
            csn_q     <= csn_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign num_csn = csn_q;
    assign num_a_g = seg_q;
    assign num_dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_pwm
// Purpose  : Self-checking bench for seg7_scan_pwm (DIGITS=4, SCAN_BITS=4):
//            vector table, directed corner sequences, randomized run
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_pwm;

    localparam int DIGITS    = 4;
    localparam int SCAN_BITS = 4;
    localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  brightness = '0;
    logic        lzs_en = 1'b0;
    logic [3:0]  num_csn;
    logic [6:0]  num_a_g;
    logic        num_dp;

    always #5 clk = ~clk;

    seg7_scan_pwm #(.DIGITS(DIGITS), .SCAN_BITS(SCAN_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .num_data   (num_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .lzs_en     (lzs_en),
        .num_csn    (num_csn),
        .num_a_g    (num_a_g),
        .num_dp     (num_dp)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  br;
        logic        lzs;
    } snap_t;

    typedef struct {
        string       name;
        snap_t       in;
        int          pos;
        logic [11:0] exp;
    } vec_t;

    snap_t       nx;
    logic        nx_rst = 1'b1;
    snap_t       snaps [2048];
    logic [6:0]  seg_tab [16];
    vec_t        tab [$];
    int          n = 0;
    int          checks = 0;
    int          failures = 0;

    // Reference: what the pins show for frame position p (cycles since frame start)
    function automatic logic [11:0] model(int p, snap_t s);
        int   slot;
        int   sub;
        logic all_zero;
        logic lit;
        slot = (p / 16) % 4;
        sub  = p % 16;
        all_zero = 1'b1;
        for (int i = 0; i <= slot; i++)
            if (s.data[4*(3-i) +: 4] != 4'h0) all_zero = 1'b0;
        lit = s.en[3-slot] && (sub < int'(s.br)) && !(s.lzs && all_zero && slot != 3);
        if (!lit) return BLANK;
        return {~(4'b1000 >> slot), seg_tab[s.data[4*(3-slot) +: 4]], ~s.dp[3-slot]};
    endfunction

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d: got csn=%b seg=%b dp=%b, want csn=%b seg=%b dp=%b",
                     name, n, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // One clock cycle: apply pending inputs after the edge, check the model mid-cycle
    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        #1;
        if (rst) n = 0; else n++;
        rst        = nx_rst;
        num_data   = nx.data;
        dp_in      = nx.dp;
        digit_en   = nx.en;
        brightness = nx.br;
        lzs_en     = nx.lzs;
        if (!rst && (n % 64) == 0) snaps[(n / 64) % 2048] = nx;
        @(negedge clk);
        e = (n < 2) ? BLANK : model(n - 2, snaps[((n - 2) / 64) % 2048]);
        chk("model", {num_csn, num_a_g, num_dp}, e);
    endtask

    task automatic do_reset(int cycles);
        nx_rst = 1'b1;
        repeat (cycles) tick();
        nx_rst = 1'b0;
    endtask

    // Run until the pins show frame position pos
    task automatic run_to(int pos);
        if (rst) tick();
        while (n < pos + 2) tick();
    endtask

    task automatic add(string name, logic [15:0] d, logic [3:0] dp, logic [3:0] en,
                       logic [3:0] br, logic lzs, int pos,
                       logic [3:0] csn, logic [6:0] seg, logic dpo);
        vec_t v;
        v.name = name; v.in.data = d; v.in.dp = dp; v.in.en = en;
        v.in.br = br; v.in.lzs = lzs; v.pos = pos; v.exp = {csn, seg, dpo};
        tab.push_back(v);
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        nx = '{data: 16'h9C3E, dp: 4'hA, en: 4'hF, br: 4'd15, lzs: 1'b0};

        // Reset hold with arbitrary inputs, then two blank cycles after release
        nx_rst = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_hold", {num_csn, num_a_g, num_dp}, BLANK);
        end
        nx = '{data: 16'h12AF, dp: 4'h0, en: 4'hF, br: 4'd15, lzs: 1'b0};
        nx_rst = 1'b0;
        tick();
        chk("reset_rel0", {num_csn, num_a_g, num_dp}, BLANK);
        tick();
        chk("reset_rel1", {num_csn, num_a_g, num_dp}, BLANK);
        tick();
        chk("reset_first", {num_csn, num_a_g, num_dp}, {4'b0111, 7'b1001111, 1'b1});

        // Vector table: {inputs, frame position, expected pins}
        add("basic_s0",     16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0,  0, 4'b0111, 7'b1001111, 1'b1);
        add("basic_s0_end", 16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 14, 4'b0111, 7'b1001111, 1'b1);
        add("basic_gap",    16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 15, 4'hF,    7'h7F,      1'b1);
        add("basic_s1",     16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 19, 4'b1011, 7'b0010010, 1'b1);
        add("basic_s2",     16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 46, 4'b1101, 7'b0001000, 1'b1);
        add("basic_s3",     16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 48, 4'b1110, 7'b0111000, 1'b1);
        add("basic_wrap",   16'h12AF, 4'h0, 4'hF, 4'd15, 1'b0, 64, 4'b0111, 7'b1001111, 1'b1);
        add("pwm4_lit",     16'h12AF, 4'h0, 4'hF, 4'd4,  1'b0,  3, 4'b0111, 7'b1001111, 1'b1);
        add("pwm4_dark",    16'h12AF, 4'h0, 4'hF, 4'd4,  1'b0,  4, 4'hF,    7'h7F,      1'b1);
        add("pwm4_s2",      16'h12AF, 4'h0, 4'hF, 4'd4,  1'b0, 35, 4'b1101, 7'b0001000, 1'b1);
        add("pwm0",         16'h12AF, 4'h0, 4'hF, 4'd0,  1'b0, 48, 4'hF,    7'h7F,      1'b1);
        add("lzs5_s0",      16'h0005, 4'h0, 4'hF, 4'd15, 1'b1,  0, 4'hF,    7'h7F,      1'b1);
        add("lzs5_s3",      16'h0005, 4'h0, 4'hF, 4'd15, 1'b1, 48, 4'b1110, 7'b0100100, 1'b1);
        add("lzs0_s2",      16'h0000, 4'h0, 4'hF, 4'd15, 1'b1, 32, 4'hF,    7'h7F,      1'b1);
        add("lzs0_s3",      16'h0000, 4'h0, 4'hF, 4'd15, 1'b1, 48, 4'b1110, 7'b0000001, 1'b1);
        add("lzs105_s0",    16'h0105, 4'h0, 4'hF, 4'd15, 1'b1,  0, 4'hF,    7'h7F,      1'b1);
        add("lzs105_s1",    16'h0105, 4'h0, 4'hF, 4'd15, 1'b1, 16, 4'b1011, 7'b1001111, 1'b1);
        add("lzs105_s2",    16'h0105, 4'h0, 4'hF, 4'd15, 1'b1, 32, 4'b1101, 7'b0000001, 1'b1);
        add("lzs_off_zero", 16'h0000, 4'h0, 4'hF, 4'd15, 1'b0,  0, 4'b0111, 7'b0000001, 1'b1);
        add("en_dp_s0",     16'h1111, 4'h8, 4'hA, 4'd15, 1'b0,  0, 4'b0111, 7'b1001111, 1'b0);
        add("en_dp_s1",     16'h1111, 4'h8, 4'hA, 4'd15, 1'b0, 16, 4'hF,    7'h7F,      1'b1);
        add("en_dp_s2",     16'h1111, 4'h8, 4'hA, 4'd15, 1'b0, 32, 4'b1101, 7'b1001111, 1'b1);
        foreach (tab[i]) begin
            nx = tab[i].in;
            do_reset(2);
            run_to(tab[i].pos);
            chk(tab[i].name, {num_csn, num_a_g, num_dp}, tab[i].exp);
        end

        // Snapshot: data changes mid slot 1, new value only from next frame
        nx = '{data: 16'h1111, dp: 4'h0, en: 4'hF, br: 4'd15, lzs: 1'b0};
        do_reset(2);
        run_to(19);
        nx.data = 16'h2222;
        run_to(24);
        chk("snap_s1_old", {num_csn, num_a_g, num_dp}, {4'b1011, 7'b1001111, 1'b1});
        run_to(50);
        chk("snap_s3_old", {num_csn, num_a_g, num_dp}, {4'b1110, 7'b1001111, 1'b1});
        run_to(65);
        chk("snap_next",   {num_csn, num_a_g, num_dp}, {4'b0111, 7'b0010010, 1'b1});

        // Reset in slot 2: blank on the next edge, restart at slot 0 two cycles later
        run_to(64 + 37);
        nx_rst = 1'b1;
        tick();
        nx_rst = 1'b0;
        tick();
        chk("midrst_blank", {num_csn, num_a_g, num_dp}, BLANK);
        tick();
        chk("midrst_blank2", {num_csn, num_a_g, num_dp}, BLANK);
        tick();
        chk("midrst_s0", {num_csn, num_a_g, num_dp}, {4'b0111, 7'b0010010, 1'b1});

        // Randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 4) begin
                for (int k = 0; k < 4; k++)
                    nx.data[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                nx.dp  = 4'($urandom);
                nx.en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                nx.br  = 4'($urandom);
                nx.lzs = 1'($urandom);
            end
            nx_rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        nx_rst = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
